ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage RV32I pipeline. It selects forwarded operands, performs the ALU operation, resolves branches and jumps, and registers results into the EX/MEM pipeline register, whose outputs drive the memory stage directly. An optional iterative multiplier can be compiled in; it stalls the front of the pipeline while it runs.

## Interface
Parameters: none.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  in  1 each  decoded controls from ID/EX
- ResultSrcE  in  2  writeback select, passed through
- ALUControlE  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed), 110 sll, 111 srl
- MulE  in  1  multiply request (meaningful only with macro)
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  in  32 each  operands and PCs from ID/EX
- RdE  in  5  destination register
- ForwardAE, ForwardBE  in  2 each  00 register file, 01 ResultW, 10 ALUResultM; 11 treated as 00
- ResultW  in  32  writeback forwarding value
- PCSrcE  out  1  (BranchE & ZeroE) | JumpE, combinational
- PCTargetE  out  32  PCE + ImmExtE, combinational, modulo 2^32
- StallE  out  1  multiplier busy; hazard unit freezes PC, IF/ID, ID/EX
- RegWriteM, MemWriteM  out  1 each  registered controls
- ResultSrcM  out  2
- ALUResultM, WriteDataM, PCPlus4M  out  32 each
- RdM  out  5

## Operation
- SrcAE = forward mux A; WriteDataE = forward mux B; SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- Add/sub are modulo 2^32. ZeroE = (ALU result == 0). slt yields 32'd1 or 32'd0 on a signed compare. Shifts use SrcBE[4:0] only.
- Each rising edge loads the EX/MEM register with the E-stage values. The register has no enable and no flush input.
- Reset drives every M output to 0: the controls, ALUResultM, WriteDataM, PCPlus4M and RdM.
- Multiplier state machine (macro on), states IDLE, BUSY, DONE:
  - IDLE with MulE=1: latch SrcAE and SrcBE after forwarding, clear the accumulator and counter, go to BUSY, assert StallE.
  - BUSY: one shift-add iteration per cycle; the counter runs 0..31. After iteration 31, go to DONE. StallE stays 1.
  - DONE: StallE=0. ALUResultE = low 32 bits of the product. State returns to IDLE at the next edge. MulE is still high in DONE because ID/EX is frozen; DONE does not start a new multiply.
- While StallE=1, the EX/MEM register captures a bubble: all controls 0, data 0.
- Operands are latched at start because the M/W forwarding sources change during the stall.
- PCSrcE is forced to 0 while StallE=1. Mul instructions never assert BranchE or JumpE.

## Timing
- ALU path: result in EX in cycle n, visible on ALUResultM in cycle n+1.
- Multiply accepted in cycle 0: StallE is high in cycles 0–32 (33 cycles), and DONE is cycle 33. The product appears on ALUResultM in cycle 34, with RegWriteM, RdM and the other controls of the mul instruction.
- Back-to-back muls: the second mul is seen in IDLE in cycle 34 and starts a new sequence.
- Reset during BUSY or DONE: state immediately goes to IDLE, StallE to 0, counter and accumulator to 0, and M outputs to 0.
- PCSrcE and PCTargetE are valid in the same cycle the instruction is in EX.

## Configuration
- EX_STAGE_MUL_EN defined: the multiplier state machine and datapath are present, and MulE selects the product as ALUResultE.
- EX_STAGE_MUL_EN undefined: MulE is ignored, StallE is tied to 0, and no multiplier state exists.
- Ports are identical in both builds.

## Structure
- Package ex_pkg:
  - alu_op_t enum for the ALUControlE encodings
  - fwd_sel_t enum (FWD_RF, FWD_W, FWD_M)
  - mul_state_t enum (IDLE, BUSY, DONE)
  - MUL_ITER constant, value 32
- Sub-module ex_mem: the EX/MEM pipeline register. It has a bubble input and asynchronous active-low reset, mirroring the existing mem_wb register style.

## Test plan
- Forwarding: RD1E=5, ForwardAE=10, ALUResultM=100, ImmExtE=3, ALUSrcE=1, add → ALUResultM=103 in the next cycle.
- beq taken: RD1E=RD2E=9, sub, BranchE=1, PCE=0x40, ImmExtE=0x10 → PCSrcE=1, PCTargetE=0x50. With RD2E=8, PCSrcE=0.
- Signed slt and shift: slt(0xFFFFFFFF, 1) → 1. sll(1, SrcB=0x21) → 2, because only the low 5 bits of SrcB are used.
- Multiply (macro on): 7×6, RegWriteE=1, RdE=5 → StallE high exactly 33 cycles with bubbles on M, then ALUResultM=42 and RdM=5. Also 0xFFFFFFFF×2 → 0xFFFFFFFE.
- Reset mid-multiply: assert reset at BUSY iteration 10 → StallE=0 and M outputs 0 asynchronously. After release, a new mul 3×3 gives 9 after the full 33-cycle stall.
- Macro off: MulE=1 with add of 2+2 → StallE stays 0, ALUResultM=4 in the next cycle.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared types for the RV32I execute stage.
//   alu_op_t    - ALUControlE encodings
//   fwd_sel_t   - operand forwarding select (11 behaves like FWD_RF)
//   mul_state_t - iterative multiplier states
//   exmem_t     - contents of the EX/MEM pipeline register
//   fwdMux      - forwarding multiplexer shared by both operand paths
package ex_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_t;

  // One shift-add iteration per multiplier bit.
  localparam int MUL_ITER = 32;

  typedef struct packed {
    logic        regWrite;
    logic        memWrite;
    logic [1:0]  resultSrc;
    logic [31:0] aluResult;
    logic [31:0] writeData;
    logic [31:0] pcPlus4;
    logic [4:0]  rd;
  } exmem_t;

  // Select 11 is unused by the hazard unit and falls back to the register file.
  function automatic logic [31:0] fwdMux(input logic [1:0]  sel,
                                         input logic [31:0] rf,
                                         input logic [31:0] resW,
                                         input logic [31:0] aluM);
    logic [31:0] v;
    case (fwd_sel_t'(sel))
      FWD_W:   v = resW;
      FWD_M:   v = aluM;
      default: v = rf;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: every ID/EX-side and EX/MEM-side signal of the execute stage.
//   master - the pipeline around EX: drives the *E controls/operands, the
//            forwarding selects and ResultW; observes branch, stall and M outputs.
//   slave  - the execute stage itself.
interface ex_stage_if;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic        MulE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;

  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;

  modport master (
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
           MulE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM,
           ALUResultM, WriteDataM, PCPlus4M, RdM
  );

  modport slave (
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
           MulE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM,
           ALUResultM, WriteDataM, PCPlus4M, RdM
  );
endinterface

// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register.
//   clk    - pipeline clock
//   reset  - asynchronous, active-low; clears every field
//   bubble - load an all-zero entry instead of dIn (multiplier stall)
//   dIn    - E-stage values to capture
//   qOut   - registered values driving the memory stage
module ex_mem
  import ex_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   bubble,
  input  exmem_t dIn,
  output exmem_t qOut
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      qOut <= '0;
    end else if (bubble) begin
      qOut <= '0;
    end else begin
      qOut <= dIn;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage RV32I pipeline.
//   clk   - pipeline clock, all state on the rising edge
//   reset - asynchronous, active-low
//   bus   - ex_stage_if.slave: ID/EX inputs, forwarding inputs, branch
//           outputs (PCSrcE, PCTargetE), StallE and the EX/MEM outputs.
// Build option: define EX_STAGE_MUL_EN to include the iterative shift-add
// multiplier. Without it MulE is ignored and StallE is constant 0.
module ex_stage
  import ex_pkg::*;
(
  input logic      clk,
  input logic      reset,
  ex_stage_if.slave bus
);

  logic [31:0] srcA, srcB, writeData;
  logic [31:0] aluResult;   // plain ALU output
  logic [31:0] aluResultE;  // ALU or multiplier result, whichever applies
  logic        zero;
  logic        stall;
  exmem_t      exmemNext, exmemReg;

  // Forwarding from ALUResultM uses the registered EX/MEM output.
  assign srcA      = fwdMux(bus.ForwardAE, bus.RD1E, bus.ResultW, bus.ALUResultM);
  assign writeData = fwdMux(bus.ForwardBE, bus.RD2E, bus.ResultW, bus.ALUResultM);
  assign srcB      = bus.ALUSrcE ? bus.ImmExtE : writeData;

  always_comb begin
    aluResult = '0;
    case (alu_op_t'(bus.ALUControlE))
      ALU_ADD: aluResult = srcA + srcB;
      ALU_SUB: aluResult = srcA - srcB;
      ALU_AND: aluResult = srcA & srcB;
      ALU_OR:  aluResult = srcA | srcB;
      ALU_XOR: aluResult = srcA ^ srcB;
      ALU_SLT: aluResult = {31'd0, $signed(srcA) < $signed(srcB)};
      ALU_SLL: aluResult = srcA << srcB[4:0];
      ALU_SRL: aluResult = srcA >> srcB[4:0];
      default: aluResult = '0;
    endcase
  end

`ifdef EX_STAGE_MUL_EN
  mul_state_t  stateReg, stateNext;
  logic [31:0] mcandReg, mplierReg, accReg;
  logic [4:0]  cntReg;

  // Operands are captured on entry because the forwarding sources move on
  // while the front of the pipeline is frozen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg  <= IDLE;
      mcandReg  <= '0;
      mplierReg <= '0;
      accReg    <= '0;
      cntReg    <= '0;
    end else begin
      stateReg <= stateNext;
      case (stateReg)
        IDLE: begin
          if (bus.MulE) begin
            mcandReg  <= srcA;
            mplierReg <= srcB;
            accReg    <= '0;
            cntReg    <= '0;
          end
        end
        BUSY: begin
          if (mplierReg[0]) begin
            accReg <= accReg + mcandReg;
          end
          mcandReg  <= mcandReg << 1;
          mplierReg <= mplierReg >> 1;
          cntReg    <= cntReg + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Stall is gated by reset so a frozen mul in ID/EX cannot hold the
  // pipeline stalled while reset is asserted.
  always_comb begin
    stateNext  = stateReg;
    stall      = 1'b0;
    aluResultE = aluResult;
    case (stateReg)
      IDLE: begin
        if (bus.MulE && reset) begin
          stateNext = BUSY;
          stall     = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cntReg == 5'(MUL_ITER - 1)) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        // MulE is still high here (ID/EX frozen); returning to IDLE instead
        // of restarting lets the same instruction retire exactly once.
        stateNext  = IDLE;
        aluResultE = accReg;
      end
      default: stateNext = IDLE;
    endcase
  end
`else
  logic unusedMulE;
  assign unusedMulE = bus.MulE;
  assign stall      = 1'b0;
  assign aluResultE = aluResult;
`endif

  assign zero          = (aluResultE == 32'd0);
  assign bus.PCSrcE    = ~stall & ((bus.BranchE & zero) | bus.JumpE);
  assign bus.PCTargetE = bus.PCE + bus.ImmExtE;
  assign bus.StallE    = stall;

  assign exmemNext = '{
    regWrite:  bus.RegWriteE,
    memWrite:  bus.MemWriteE,
    resultSrc: bus.ResultSrcE,
    aluResult: aluResultE,
    writeData: writeData,
    pcPlus4:   bus.PCPlus4E,
    rd:        bus.RdE
  };

  ex_mem uExMem (
    .clk    (clk),
    .reset  (reset),
    .bubble (stall),
    .dIn    (exmemNext),
    .qOut   (exmemReg)
  );

  assign bus.RegWriteM  = exmemReg.regWrite;
  assign bus.MemWriteM  = exmemReg.memWrite;
  assign bus.ResultSrcM = exmemReg.resultSrc;
  assign bus.ALUResultM = exmemReg.aluResult;
  assign bus.WriteDataM = exmemReg.writeData;
  assign bus.PCPlus4M   = exmemReg.pcPlus4;
  assign bus.RdM        = exmemReg.rd;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed plus randomized bench for ex_stage. A reference model
// predicts branch outputs, StallE and the EX/MEM register every cycle from
// the instruction-level rules; directed cases pin literal results.
module tb_ex_stage;
  import ex_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  ex_stage_if ifc ();

  ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

`ifdef EX_STAGE_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  exmem_t      expM  = '0;   // what the EX/MEM register must hold now
  exmem_t      pendM = '0;   // what it must hold after the next edge
  bit          mBusy = 1'b0, pBusy = 1'b0;
  int          mAge  = 0,    pAge  = 0;   // cycles since the mul was accepted
  logic [31:0] mProd = '0,   pProd = '0;
  bit          lastExpStall = 1'b0;

  function automatic logic [31:0] aluModel(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6:    return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  function automatic logic [31:0] fwdModel(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'd1) return ifc.ResultW;
    if (sel == 2'd2) return expM.aluResult;
    return rf;
  endfunction

  // Register update of the model.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      expM  = '0;
      mBusy = 1'b0;
      mAge  = 0;
      mProd = '0;
    end else begin
      expM  = pendM;
      mBusy = pBusy;
      mAge  = pAge;
      mProd = pProd;
    end
  end

  // Compare process: checks every cycle on the falling edge.
  initial forever begin : cmp
    logic [31:0] a, wd, b, res;
    bit stall, accept, pcs;
    @(negedge clk);
    if (!reset) begin
      check("rst_StallE", ifc.StallE, 32'd0);
      check("rst_ALUResultM", ifc.ALUResultM, 32'd0);
      check("rst_ctrlM", {ifc.RegWriteM, ifc.MemWriteM, ifc.ResultSrcM, ifc.RdM}, 32'd0);
      check("rst_dataM", ifc.WriteDataM | ifc.PCPlus4M, 32'd0);
      pendM = '0;
      pBusy = 1'b0;
      pAge  = 0;
      lastExpStall = 1'b0;
    end else begin
      a   = fwdModel(ifc.ForwardAE, ifc.RD1E);
      wd  = fwdModel(ifc.ForwardBE, ifc.RD2E);
      b   = ifc.ALUSrcE ? ifc.ImmExtE : wd;
      res = aluModel(ifc.ALUControlE, a, b);
      stall  = 1'b0;
      accept = 1'b0;
      if (mBusy) begin
        if (mAge <= 32) stall = 1'b1;
        else            res   = mProd;
      end else if (MUL_ON && ifc.MulE) begin
        stall  = 1'b1;
        accept = 1'b1;
      end
      pcs = !stall && ((ifc.BranchE && res == 32'd0) || ifc.JumpE);

      check("PCSrcE", ifc.PCSrcE, pcs);
      check("PCTargetE", ifc.PCTargetE, ifc.PCE + ifc.ImmExtE);
      check("StallE", ifc.StallE, stall);
      check("ALUResultM", ifc.ALUResultM, expM.aluResult);
      check("WriteDataM", ifc.WriteDataM, expM.writeData);
      check("PCPlus4M", ifc.PCPlus4M, expM.pcPlus4);
      check("ctrlM", {ifc.RegWriteM, ifc.MemWriteM, ifc.ResultSrcM, ifc.RdM},
            {expM.regWrite, expM.memWrite, expM.resultSrc, expM.rd});

      if (stall) pendM = '0;
      else pendM = '{regWrite: ifc.RegWriteE, memWrite: ifc.MemWriteE,
                     resultSrc: ifc.ResultSrcE, aluResult: res, writeData: wd,
                     pcPlus4: ifc.PCPlus4E, rd: ifc.RdE};

      pProd = mProd;
      if (accept) begin
        pBusy = 1'b1;
        pAge  = 1;
        pProd = a * b;
      end else if (mBusy && mAge < 33) begin
        pBusy = 1'b1;
        pAge  = mAge + 1;
      end else begin
        pBusy = 1'b0;
        pAge  = 0;
      end
      lastExpStall = stall;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setNop();
    ifc.RegWriteE = 0; ifc.MemWriteE = 0; ifc.JumpE = 0; ifc.BranchE = 0;
    ifc.ALUSrcE = 0; ifc.ResultSrcE = 0; ifc.ALUControlE = 0; ifc.MulE = 0;
    ifc.RD1E = 0; ifc.RD2E = 0; ifc.ImmExtE = 0; ifc.PCE = 0; ifc.PCPlus4E = 0;
    ifc.RdE = 0; ifc.ForwardAE = 0; ifc.ForwardBE = 0; ifc.ResultW = 0;
  endtask

  task automatic randomInputs();
    ifc.MulE        = ($urandom_range(0, 15) == 0);
    ifc.RegWriteE   = 1'($urandom);
    ifc.MemWriteE   = 1'($urandom);
    ifc.ResultSrcE  = 2'($urandom);
    ifc.ALUControlE = 3'($urandom);
    ifc.ALUSrcE     = 1'($urandom);
    ifc.BranchE     = !ifc.MulE && 1'($urandom);
    ifc.JumpE       = !ifc.MulE && ($urandom_range(0, 7) == 0);
    ifc.RD1E        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    ifc.RD2E        = ($urandom_range(0, 2) == 0) ? ifc.RD1E : $urandom;
    ifc.ImmExtE     = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
    ifc.PCE         = $urandom & 32'hFFFF_FFFC;
    ifc.PCPlus4E    = ifc.PCE + 32'd4;
    ifc.RdE         = 5'($urandom);
    ifc.ForwardAE   = 2'($urandom);
    ifc.ForwardBE   = 2'($urandom);
    ifc.ResultW     = $urandom;
  endtask

  task automatic runMul(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] prod);
    int n;
    setNop();
    ifc.MulE = 1; ifc.RD1E = a; ifc.RD2E = b; ifc.RegWriteE = 1; ifc.RdE = rd;
    n = 0;
    #2;
    while (ifc.StallE && n < 100) begin
      n++;
      tick();
      #2;
    end
    check({nm, "_stall_cycles"}, 32'(n), 32'd33);
    tick();
    check({nm, "_ALUResultM"}, ifc.ALUResultM, prod);
    check({nm, "_RdM"}, {27'd0, ifc.RdM}, {27'd0, rd});
    check({nm, "_RegWriteM"}, ifc.RegWriteM, 32'd1);
  endtask

  initial begin
    setNop();
    #1 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;

    // forwarding from M: seed ALUResultM with 100, then 5 -> fwd 100 + 3
    ifc.RD1E = 100; ifc.ALUSrcE = 1; ifc.RegWriteE = 1; ifc.RdE = 3;
    tick();
    check("seed_ALUResultM", ifc.ALUResultM, 32'd100);
    setNop(); ifc.RD1E = 5; ifc.ForwardAE = 2'b10; ifc.ImmExtE = 3; ifc.ALUSrcE = 1;
    tick();
    check("fwdM_add", ifc.ALUResultM, 32'd103);

    // forwarding from W on A, sub: 20 - 7
    setNop(); ifc.RD1E = 1; ifc.ResultW = 20; ifc.ForwardAE = 2'b01; ifc.RD2E = 7;
    ifc.ALUControlE = 3'b001;
    tick();
    check("fwdW_sub", ifc.ALUResultM, 32'd13);

    // beq taken / not taken
    setNop(); ifc.RD1E = 9; ifc.RD2E = 9; ifc.ALUControlE = 3'b001; ifc.BranchE = 1;
    ifc.PCE = 32'h40; ifc.ImmExtE = 32'h10;
    #2;
    check("beq_taken", ifc.PCSrcE, 32'd1);
    check("beq_target", ifc.PCTargetE, 32'h50);
    ifc.RD2E = 8;
    #1;
    check("beq_not_taken", ifc.PCSrcE, 32'd0);
    tick();

    // slt signed, sll/srl use only 5 shift bits
    setNop(); ifc.RD1E = 32'hFFFF_FFFF; ifc.RD2E = 1; ifc.ALUControlE = 3'b101;
    tick();
    check("slt_signed", ifc.ALUResultM, 32'd1);
    setNop(); ifc.RD1E = 1; ifc.ALUSrcE = 1; ifc.ImmExtE = 32'h21; ifc.ALUControlE = 3'b110;
    tick();
    check("sll_5bit", ifc.ALUResultM, 32'd2);
    setNop(); ifc.RD1E = 32'h8000_0000; ifc.ALUSrcE = 1; ifc.ImmExtE = 32'h3F;
    ifc.ALUControlE = 3'b111;
    tick();
    check("srl_5bit", ifc.ALUResultM, 32'd1);

    // asynchronous reset with live M contents
    setNop(); ifc.RD1E = 32'h55; ifc.RegWriteE = 1; ifc.RdE = 7; ifc.PCPlus4E = 32'h104;
    tick();
    check("pre_rst_ALUResultM", ifc.ALUResultM, 32'h55);
    #2 reset = 1'b0;
    #1;
    check("async_rst_ALUResultM", ifc.ALUResultM, 32'd0);
    check("async_rst_RdM", {27'd0, ifc.RdM}, 32'd0);
    check("async_rst_PCPlus4M", ifc.PCPlus4M, 32'd0);
    tick();
    reset = 1'b1;

`ifdef EX_STAGE_MUL_EN
    runMul("mul7x6", 32'd7, 32'd6, 5'd5, 32'd42);
    runMul("mulFFx2", 32'hFFFF_FFFF, 32'd2, 5'd6, 32'hFFFF_FFFE);  // back-to-back

    // reset during BUSY iteration 10 (cycle 11 after acceptance)
    setNop(); ifc.MulE = 1; ifc.RD1E = 11; ifc.RD2E = 13; ifc.RegWriteE = 1; ifc.RdE = 9;
    repeat (11) tick();
    #2;
    check("mid_mul_StallE", ifc.StallE, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_StallE", ifc.StallE, 32'd0);
    check("mid_rst_ALUResultM", ifc.ALUResultM, 32'd0);
    check("mid_rst_ctrlM", {ifc.RegWriteM, ifc.RdM}, 32'd0);
    tick();
    reset = 1'b1;
    runMul("mul3x3", 32'd3, 32'd3, 5'd4, 32'd9);
`else
    setNop(); ifc.MulE = 1; ifc.RD1E = 2; ifc.ImmExtE = 2; ifc.ALUSrcE = 1;
    #2;
    check("nomul_StallE", ifc.StallE, 32'd0);
    tick();
    check("nomul_add", ifc.ALUResultM, 32'd4);
`endif

    // randomized traffic; inputs held while the model says the stage stalls
    for (int c = 0; c < 600; c++) begin
      if (!lastExpStall) randomInputs();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
